regfile_write_scheduler: RTL and testbench



---
 rtl/regfile_write_scheduler_pkg.sv | 35 +++
 rtl/regfile_write_scheduler_if.sv | 40 ++++
 rtl/regfile_write_scheduler_rr_pick2.sv | 52 +++++
 rtl/regfile_write_scheduler.sv | 154 +++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aap_regfile_pkg
//  Description : Shared widths, state encoding and round-robin helper for the
//                register-file write-back scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package aap_regfile_pkg;

    localparam int NUM_REQ     = 3;
    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 16;
    localparam int NUM_REGS    = 64;
    localparam int CLEAR_PAIRS = NUM_REGS / 2;
    localparam int CNT_W       = $clog2(CLEAR_PAIRS);
    localparam int PTR_W       = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // (base + step) mod NUM_REQ for pointer values already inside 0..NUM_REQ-1
    function automatic logic [PTR_W-1:0] rr_wrap(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] step);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        return sum[PTR_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_scheduler_if
//  Description : Requester handshake, clear control and register-file write
//                port bundle. master = requesters/controller, slave = scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_scheduler_if;
    import aap_regfile_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_reg;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           clear_start;
    logic                           busy;
    logic                           clear_done;
    logic [ADDR_W-1:0]              reg_wr1;
    logic [ADDR_W-1:0]              reg_wr2;
    logic [DATA_W-1:0]              reg_wr1_data;
    logic [DATA_W-1:0]              reg_wr2_data;
    logic                           reg_wr1_enable;
    logic                           reg_wr2_enable;

    modport master (
        output req_valid, req_reg, req_data, clear_start,
        input  req_ready, busy, clear_done,
        input  reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data,
        input  reg_wr1_enable, reg_wr2_enable
    );

    modport slave (
        input  req_valid, req_reg, req_data, clear_start,
        output req_ready, busy, clear_done,
        output reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data,
        output reg_wr1_enable, reg_wr2_enable
    );

endinterface
`default_nettype wire

// File: rtl/regfile_write_scheduler_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational round-robin picker granting up to two
//                requesters per cycle, never two to the same register.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import aap_regfile_pkg::*;
(
    input  logic [NUM_REQ-1:0]             valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] dest,
    input  logic [PTR_W-1:0]               ptr,
    output logic [NUM_REQ-1:0]             gnt1,
    output logic [NUM_REQ-1:0]             gnt2,
    output logic [PTR_W-1:0]               ptr_next
);

    logic [PTR_W-1:0]  idx;
    logic [ADDR_W-1:0] first_dest;
    logic              have1;
    logic              have2;

    // Walk ptr, ptr+1, ptr+2; a second candidate aimed at the first grant's
    // register is passed over so the next one in line can still use port 2.
    always_comb begin
        gnt1       = '0;
        gnt2       = '0;
        ptr_next   = ptr;
        first_dest = '0;
        have1      = 1'b0;
        have2      = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_wrap(ptr, PTR_W'(k));
            if (valid[idx]) begin
                if (!have1) begin
                    have1      = 1'b1;
                    gnt1[idx]  = 1'b1;
                    first_dest = dest[idx];
                    ptr_next   = rr_wrap(idx, PTR_W'(1));
                end else if (!have2 && (dest[idx] != first_dest)) begin
                    have2      = 1'b1;
                    gnt2[idx]  = 1'b1;
                    ptr_next   = rr_wrap(idx, PTR_W'(1));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_scheduler
//  Description : Shares the register file's two write ports between three
//                write-back requesters and runs a whole-file clear on demand.
//                All write-port outputs are registered (one cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler
    import aap_regfile_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    regfile_write_scheduler_if.slave bus
);

    state_t            state_q,      state_d;
    logic [PTR_W-1:0]  ptr_q,        ptr_d;
    logic [CNT_W-1:0]  clr_cnt_q,    clr_cnt_d;
    logic [ADDR_W-1:0] wr1_addr_q,   wr1_addr_d;
    logic [ADDR_W-1:0] wr2_addr_q,   wr2_addr_d;
    logic [DATA_W-1:0] wr1_data_q,   wr1_data_d;
    logic [DATA_W-1:0] wr2_data_q,   wr2_data_d;
    logic              wr1_en_q,     wr1_en_d;
    logic              wr2_en_q,     wr2_en_d;
    logic              busy_q,       busy_d;
    logic              clear_done_q, clear_done_d;

    logic [NUM_REQ-1:0] w_gnt1;
    logic [NUM_REQ-1:0] w_gnt2;
    logic [PTR_W-1:0]   w_ptr_pick;
    logic [NUM_REQ-1:0] w_ready;

    rr_pick2 u_pick (
        .valid    (bus.req_valid),
        .dest     (bus.req_reg),
        .ptr      (ptr_q),
        .gnt1     (w_gnt1),
        .gnt2     (w_gnt2),
        .ptr_next (w_ptr_pick)
    );

    // Next-state and next write-port contents: arbitration in IDLE, one
    // zero-filled register pair per cycle in CLEAR.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_cnt_d    = clr_cnt_q;
        wr1_addr_d   = wr1_addr_q;
        wr2_addr_d   = wr2_addr_q;
        wr1_data_d   = wr1_data_q;
        wr2_data_d   = wr2_data_q;
        wr1_en_d     = 1'b0;
        wr2_en_d     = 1'b0;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;
        w_ready      = '0;

        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    // Pair 0 is issued right away so it shows in the next cycle.
                    state_d    = CLEAR;
                    clr_cnt_d  = CNT_W'(1);
                    wr1_addr_d = ADDR_W'(0);
                    wr2_addr_d = ADDR_W'(1);
                    wr1_data_d = '0;
                    wr2_data_d = '0;
                    wr1_en_d   = 1'b1;
                    wr2_en_d   = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    w_ready = w_gnt1 | w_gnt2;
                    if (|w_gnt1) begin
                        ptr_d    = w_ptr_pick;
                        wr1_en_d = 1'b1;
                        wr2_en_d = |w_gnt2;
                    end
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_gnt1[i]) begin
                            wr1_addr_d = bus.req_reg[i];
                            wr1_data_d = bus.req_data[i];
                        end
                        if (w_gnt2[i]) begin
                            wr2_addr_d = bus.req_reg[i];
                            wr2_data_d = bus.req_data[i];
                        end
                    end
                end
            end
            CLEAR: begin
                wr1_addr_d = {clr_cnt_q, 1'b0};
                wr2_addr_d = {clr_cnt_q, 1'b1};
                wr1_data_d = '0;
                wr2_data_d = '0;
                wr1_en_d   = 1'b1;
                wr2_en_d   = 1'b1;
                busy_d     = 1'b1;
                if (clr_cnt_q == CNT_W'(CLEAR_PAIRS - 1)) begin
                    clear_done_d = 1'b1;
                    clr_cnt_d    = '0;
                    state_d      = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, clear counter and write-port registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            clr_cnt_q    <= '0;
            wr1_addr_q   <= '0;
            wr2_addr_q   <= '0;
            wr1_data_q   <= '0;
            wr2_data_q   <= '0;
            wr1_en_q     <= 1'b0;
            wr2_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_cnt_q    <= clr_cnt_d;
            wr1_addr_q   <= wr1_addr_d;
            wr2_addr_q   <= wr2_addr_d;
            wr1_data_q   <= wr1_data_d;
            wr2_data_q   <= wr2_data_d;
            wr1_en_q     <= wr1_en_d;
            wr2_en_q     <= wr2_en_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Grants are withheld while reset is asserted so nothing transfers then.
    assign bus.req_ready      = w_ready & {NUM_REQ{reset}};
    assign bus.reg_wr1        = wr1_addr_q;
    assign bus.reg_wr2        = wr2_addr_q;
    assign bus.reg_wr1_data   = wr1_data_q;
    assign bus.reg_wr2_data   = wr2_data_q;
    assign bus.reg_wr1_enable = wr1_en_q;
    assign bus.reg_wr2_enable = wr2_en_q;
    assign bus.busy           = busy_q;
    assign bus.clear_done     = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_scheduler
//  Description : Directed plus randomized bench for the write-back scheduler
//                with a behavioural timeline model of grants, clears and
//                register-file contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_scheduler;
    import aap_regfile_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_write_scheduler_if bus();

    regfile_write_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: values the ports are expected to show in the current cycle.
    logic        m_e1, m_e2, m_busy, m_done;
    logic [5:0]  m_a1, m_a2;
    logic [15:0] m_d1, m_d2;
    int          m_ptr;
    bit          m_clearing;
    int          m_pair;
    logic [15:0] m_rf [64];
    logic [15:0] o_rf [64];
    logic [2:0]  last_ready;
    int          busy_seen;
    int          done_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check ports and req_ready at the falling edge, advance
    // the model, then return just after the rising edge for new stimulus.
    task automatic step();
        logic [2:0]  exp_ready;
        logic        n_e1, n_e2, n_busy, n_done;
        logic [5:0]  n_a1, n_a2;
        logic [15:0] n_d1, n_d2;
        int          order[$];
        int          g[$];
        int          i;
        @(negedge clock);
        check("ports",
              {16'h0, bus.reg_wr1_enable, bus.reg_wr1, bus.reg_wr1_data,
               bus.reg_wr2_enable, bus.reg_wr2, bus.reg_wr2_data, bus.busy, bus.clear_done},
              {16'h0, m_e1, m_a1, m_d1, m_e2, m_a2, m_d2, m_busy, m_done});
        if (bus.busy) busy_seen++;
        if (bus.clear_done) done_seen++;
        if (bus.reg_wr1_enable) o_rf[bus.reg_wr1] = bus.reg_wr1_data;
        if (bus.reg_wr2_enable) o_rf[bus.reg_wr2] = bus.reg_wr2_data;
        if (m_e1) m_rf[m_a1] = m_d1;
        if (m_e2) m_rf[m_a2] = m_d2;

        exp_ready = '0;
        n_e1 = 1'b0; n_e2 = 1'b0; n_busy = 1'b0; n_done = 1'b0;
        n_a1 = m_a1; n_a2 = m_a2; n_d1 = m_d1; n_d2 = m_d2;
        if (!reset) begin
            n_a1 = '0; n_a2 = '0; n_d1 = '0; n_d2 = '0;
            m_ptr = 0; m_clearing = 0; m_pair = 0;
        end else if (m_clearing) begin
            n_e1 = 1'b1; n_e2 = 1'b1; n_d1 = '0; n_d2 = '0; n_busy = 1'b1;
            n_a1 = 6'(2 * m_pair);
            n_a2 = 6'(2 * m_pair + 1);
            n_done = (m_pair == 31);
            m_pair++;
            if (m_pair == 32) m_clearing = 0;
        end else if (bus.clear_start) begin
            n_e1 = 1'b1; n_e2 = 1'b1; n_d1 = '0; n_d2 = '0; n_busy = 1'b1;
            n_a1 = 6'd0; n_a2 = 6'd1;
            m_pair = 1; m_clearing = 1;
        end else begin
            for (int k = 0; k < 3; k++) order.push_back((m_ptr + k) % 3);
            foreach (order[j]) begin
                i = order[j];
                if (bus.req_valid[i]) begin
                    if (g.size() == 0) g.push_back(i);
                    else if (g.size() == 1 && bus.req_reg[i] != bus.req_reg[g[0]]) g.push_back(i);
                end
            end
            foreach (g[j]) exp_ready[g[j]] = 1'b1;
            if (g.size() >= 1) begin
                n_e1 = 1'b1; n_a1 = bus.req_reg[g[0]]; n_d1 = bus.req_data[g[0]];
                m_ptr = (g[g.size()-1] + 1) % 3;
            end
            if (g.size() >= 2) begin
                n_e2 = 1'b1; n_a2 = bus.req_reg[g[1]]; n_d2 = bus.req_data[g[1]];
            end
        end
        last_ready = bus.req_ready;
        check("req_ready", {61'h0, bus.req_ready}, {61'h0, exp_ready});
        @(posedge clock);
        #1;
        m_e1 = n_e1; m_e2 = n_e2; m_a1 = n_a1; m_a2 = n_a2;
        m_d1 = n_d1; m_d2 = n_d2; m_busy = n_busy; m_done = n_done;
    endtask

    initial begin
        for (int r = 0; r < 64; r++) begin
            m_rf[r] = '0;
            o_rf[r] = '0;
        end
        m_e1 = 0; m_e2 = 0; m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0;
        m_busy = 0; m_done = 0; m_ptr = 0; m_clearing = 0; m_pair = 0;
        busy_seen = 0; done_seen = 0; last_ready = '0;

        // Reset held low with every requester asking.
        reset           = 1'b0;
        bus.clear_start = 1'b0;
        bus.req_valid   = 3'b111;
        bus.req_reg[0]  = 6'd10; bus.req_data[0] = 16'h0a0a;
        bus.req_reg[1]  = 6'd11; bus.req_data[1] = 16'h0b0b;
        bus.req_reg[2]  = 6'd12; bus.req_data[2] = 16'h0c0c;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_ready", {61'h0, last_ready}, 64'h0);
        end
        check("rst_outputs", {61'h0, bus.reg_wr1_enable, bus.reg_wr2_enable, bus.busy}, 64'h0);
        reset = 1'b1;
        step();
        check("rst_first_grant", {61'h0, last_ready}, 64'h3);
        bus.req_valid = 3'b100;
        step();
        bus.req_valid = 3'b000;
        step();

        // Single write from requester 0 (pointer is back at 0).
        bus.req_valid = 3'b001; bus.req_reg[0] = 6'd5; bus.req_data[0] = 16'h1234;
        step();
        check("single_ready", {61'h0, last_ready}, 64'h1);
        bus.req_valid = 3'b000;
        check("single_ports", {40'h0, bus.reg_wr1_enable, bus.reg_wr1, bus.reg_wr1_data, bus.reg_wr2_enable},
              {40'h0, 1'b1, 6'd5, 16'h1234, 1'b0});
        bus.req_valid = 3'b100; bus.req_reg[2] = 6'd20; bus.req_data[2] = 16'h2020;
        step();
        bus.req_valid = 3'b000;
        step();

        // Three-way contention from pointer 0.
        bus.req_valid = 3'b111;
        bus.req_reg[0] = 6'd3; bus.req_data[0] = 16'h0003;
        bus.req_reg[1] = 6'd4; bus.req_data[1] = 16'h0004;
        bus.req_reg[2] = 6'd6; bus.req_data[2] = 16'h0006;
        step();
        check("three_c0_ready", {61'h0, last_ready}, 64'h3);
        check("three_c0_ports", {48'h0, bus.reg_wr1_enable, bus.reg_wr1, bus.reg_wr2_enable, bus.reg_wr2},
              {48'h0, 1'b1, 6'd3, 1'b1, 6'd4});
        bus.req_valid = 3'b100;
        step();
        check("three_c1_ready", {61'h0, last_ready}, 64'h4);
        check("three_c1_ports", {48'h0, bus.reg_wr1_enable, bus.reg_wr1, bus.reg_wr2_enable, 6'h0},
              {48'h0, 1'b1, 6'd6, 1'b0, 6'h0});
        bus.req_valid = 3'b000;

        // Two requesters to register 7: only one per cycle, later one wins.
        bus.req_valid = 3'b011;
        bus.req_reg[0] = 6'd7; bus.req_data[0] = 16'hAAAA;
        bus.req_reg[1] = 6'd7; bus.req_data[1] = 16'h5555;
        step();
        check("collide_c0_ready", {61'h0, last_ready}, 64'h1);
        bus.req_valid = 3'b010;
        step();
        check("collide_c1_ready", {61'h0, last_ready}, 64'h2);
        bus.req_valid = 3'b000;
        step();
        step();
        check("collide_reg7", {48'h0, o_rf[7]}, {48'h0, 16'h5555});

        // Clear pass with requester 0 waiting throughout.
        busy_seen = 0; done_seen = 0;
        bus.clear_start = 1'b1;
        bus.req_valid = 3'b001; bus.req_reg[0] = 6'd9; bus.req_data[0] = 16'hBEEF;
        step();
        check("clear_t0_ready", {61'h0, last_ready}, 64'h0);
        check("clear_pair0", {52'h0, bus.reg_wr1, bus.reg_wr2}, {52'h0, 6'd0, 6'd1});
        for (int k = 1; k < 32; k++) begin
            if (k == 4) bus.clear_start = 1'b0;
            step();
            check("clear_hold_ready", {61'h0, last_ready}, 64'h0);
        end
        step();
        check("clear_resume_ready", {61'h0, last_ready}, 64'h1);
        bus.req_valid = 3'b000;
        step();
        check("clear_busy_cycles", 64'(busy_seen), 64'd32);
        check("clear_done_pulses", 64'(done_seen), 64'd1);

        // Reset in the 10th clear cycle, then a fresh pass.
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_outputs", {61'h0, bus.reg_wr1_enable, bus.reg_wr2_enable, bus.busy}, 64'h0);
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        check("restart_pair0", {48'h0, bus.reg_wr1_enable, bus.reg_wr2_enable, bus.busy, bus.reg_wr1, bus.reg_wr2, 1'b0},
              {48'h0, 1'b1, 1'b1, 1'b1, 6'd0, 6'd1, 1'b0});
        for (int k = 0; k < 33; k++) step();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 800; n++) begin
            bus.clear_start = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 149) != 0);
            step();
            for (int r = 0; r < 3; r++) begin
                if (last_ready[r] || !bus.req_valid[r]) begin
                    bus.req_valid[r] = ($urandom_range(0, 3) != 0);
                    bus.req_reg[r]   = 6'($urandom_range(0, 7));
                    bus.req_data[r]  = 16'($urandom);
                end
            end
        end
        bus.req_valid = 3'b000;
        bus.clear_start = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 40; k++) step();
        for (int r = 0; r < 64; r++) begin
            check("regfile_contents", {48'h0, o_rf[r]}, {48'h0, m_rf[r]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
